// File: rtl/gust_pkg.sv
// Shared definitions for the GUST SpMV datapath: feeder FSM states,
// slot width and per-field bit offsets within a packed schedule slot.
// Slot packing, LSB first: val, vec_val, ind, signals (lane 0 in LSBs).
package gust_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Width of one packed slot.
  function automatic int unsigned slot_width(input int unsigned n,
                                             input int unsigned vs,
                                             input int unsigned is);
    return n * (2 * vs + is + 1);
  endfunction

  function automatic int unsigned val_off();
    return 0;
  endfunction

  function automatic int unsigned vec_val_off(input int unsigned n,
                                              input int unsigned vs);
    return n * vs;
  endfunction

  function automatic int unsigned ind_off(input int unsigned n,
                                          input int unsigned vs);
    return 2 * n * vs;
  endfunction

  function automatic int unsigned sig_off(input int unsigned n,
                                          input int unsigned vs,
                                          input int unsigned is);
    return 2 * n * vs + n * is;
  endfunction

endpackage

// File: rtl/gust_schedule_ram.sv
// Schedule buffer: DEPTH x W register array, synchronous write,
// combinational read, no reset.
// Ports: clk, wr_en_i/wr_addr_i/wr_data_i (write), rd_addr_i/rd_data_o (read).
module gust_schedule_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned W     = 136
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/gust_schedule_feeder.sv
// Schedule feeder for the GUST SpMV core: holds a schedule of packed slots
// and, on go, issues a start pulse, streams the slots one per cycle (hold
// inserts bubbles), then pulses done. All outputs are registered.
// Ports: clk, rst (async, active-high); wr_en/wr_addr/wr_data (load slots,
// ignored while busy); len/go (launch stream); hold (stall); busy/done/start
// (status); val/vec_val/ind/signals (slot fields to main).
module gust_schedule_feeder
  import gust_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned value_size = 32,
  parameter int unsigned index_size = 3,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned W          = slot_width(N, value_size, index_size)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [W-1:0]            wr_data,
  input  logic [AW:0]             len,
  input  logic                    go,
  input  logic                    hold,
  output logic                    busy,
  output logic                    done,
  output logic                    start,
  output logic [N*value_size-1:0] val,
  output logic [N*value_size-1:0] vec_val,
  output logic [N*index_size-1:0] ind,
  output logic [N-1:0]            signals
);

  localparam int unsigned VAL_OFF = val_off();
  localparam int unsigned VEC_OFF = vec_val_off(N, value_size);
  localparam int unsigned IND_OFF = ind_off(N, value_size);
  localparam int unsigned SIG_OFF = sig_off(N, value_size, index_size);

  state_e       state_q, state_d;
  logic [AW:0]  ptr_q, ptr_d;
  logic [AW:0]  len_q, len_d;
  logic [W-1:0] slot_q, slot_d;
  logic         start_q, start_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [W-1:0] rd_data;

  // Schedule is frozen while a stream is in flight.
  gust_schedule_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en && !busy_q),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    slot_d  = '0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (go) begin
          busy_d = 1'b1;
          if (len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            start_d = 1'b1;
            ptr_d   = '0;
            len_d   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
          end
        end
      end
      // Slot 0 always follows start directly; hold is not sampled here.
      START: begin
        state_d = STREAM;
        slot_d  = rd_data;
        ptr_d   = ptr_q + (AW+1)'(1);
      end
      STREAM: begin
        if (ptr_q >= len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (!hold) begin
          slot_d = rd_data;
          ptr_d  = ptr_q + (AW+1)'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      slot_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      slot_q  <= slot_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign start   = start_q;
  assign val     = slot_q[VAL_OFF +: N*value_size];
  assign vec_val = slot_q[VEC_OFF +: N*value_size];
  assign ind     = slot_q[IND_OFF +: N*index_size];
  assign signals = slot_q[SIG_OFF +: N];

endmodule

// File: tb/tb_gust_schedule_feeder.sv
// Directed bench for gust_schedule_feeder: each cycle compares
// {busy,start,done,slot} against hand-built expectations.
module tb_gust_schedule_feeder;

  localparam int unsigned W  = 136;
  localparam int unsigned OW = W + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [4:0]    len = '0;
  logic          go = 1'b0;
  logic          hold = 1'b0;
  logic          busy, done, start;
  logic [63:0]   val, vec_val;
  logic [5:0]    ind;
  logic [1:0]    signals;

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] s0, s1, s_new, junk;
  logic [W-1:0] big [16];

  gust_schedule_feeder dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .go      (go),
    .hold    (hold),
    .busy    (busy),
    .done    (done),
    .start   (start),
    .val     (val),
    .vec_val (vec_val),
    .ind     (ind),
    .signals (signals)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [31:0] v0, input logic [31:0] v1,
                                      input logic [31:0] x0, input logic [31:0] x1,
                                      input logic [2:0] i0, input logic [2:0] i1,
                                      input logic [1:0] sg);
    return {sg, i1, i0, x1, x0, v1, v0};
  endfunction

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h want %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic chk_o(input string tag, input logic b, input logic s, input logic d,
                       input logic [W-1:0] slot);
    chk(tag, {busy, start, done, signals, ind, vec_val, val}, {b, s, d, slot});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Launch a stream; returns in the cycle after go is sampled.
  task automatic launch(input logic [4:0] l);
    len = l; go = 1'b1;
    step();
    go = 1'b0;
  endtask

  initial begin
    s0    = mk(32'h3F8CCCCD, 32'h40066666, 32'h3F8CCCCD, 32'h40066666, 3'd1, 3'd2, 2'b00);
    s1    = mk(32'h0, 32'h0, 32'h0, 32'h0, 3'd2, 3'd1, 2'b11);
    s_new = mk(32'hCAFEF00D, 32'h12345678, 32'h0BADBEEF, 32'h87654321, 3'd7, 3'd5, 2'b01);
    junk  = mk(32'hDEADDEAD, 32'hDEADDEAD, 32'hDEADDEAD, 32'hDEADDEAD, 3'd6, 3'd6, 2'b10);
    for (int i = 0; i < 16; i++)
      big[i] = mk(32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 32'h4000 + i,
                  3'(i), ~3'(i), 2'(i));

    #1 rst = 1'b1;
    #1 chk_o("reset", 0, 0, 0, '0);
    #10 rst = 1'b0;
    step();
    chk_o("idle after reset", 0, 0, 0, '0);

    // Basic two-slot stream.
    wr(4'd0, s0);
    wr(4'd1, s1);
    launch(5'd2);
    chk_o("t1 start", 1, 1, 0, '0);
    step(); chk_o("t1 slot0", 1, 0, 0, s0);
    step(); chk_o("t1 slot1", 1, 0, 0, s1);
    step(); chk_o("t1 done", 1, 0, 1, '0);
    step(); chk_o("t1 idle", 0, 0, 0, '0);

    // One hold cycle between slot0 and slot1.
    launch(5'd2);
    chk_o("t2 start", 1, 1, 0, '0);
    step(); chk_o("t2 slot0", 1, 0, 0, s0);
    hold = 1'b1;
    step(); hold = 1'b0;
    chk_o("t2 bubble", 1, 0, 0, '0);
    step(); chk_o("t2 slot1", 1, 0, 0, s1);
    step(); chk_o("t2 done", 1, 0, 1, '0);
    step(); chk_o("t2 idle", 0, 0, 0, '0);

    // len = 0: immediate done, no start.
    launch(5'd0);
    chk_o("t3 done", 1, 0, 1, '0);
    step(); chk_o("t3 idle", 0, 0, 0, '0);

    // len = 20 clamps to 16 slots.
    for (int i = 0; i < 16; i++) wr(4'(i), big[i]);
    launch(5'd20);
    chk_o("t4 start", 1, 1, 0, '0);
    for (int i = 0; i < 16; i++) begin
      step(); chk_o($sformatf("t4 slot%0d", i), 1, 0, 0, big[i]);
    end
    step(); chk_o("t4 done", 1, 0, 1, '0);
    step(); chk_o("t4 idle", 0, 0, 0, '0);

    // Writes and go during a stream are ignored.
    launch(5'd2);
    chk_o("t5 start", 1, 1, 0, '0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = junk; go = 1'b1; len = 5'd1;
    step();
    chk_o("t5 slot0", 1, 0, 0, big[0]);
    step(); chk_o("t5 slot1", 1, 0, 0, big[1]);
    step(); chk_o("t5 done", 1, 0, 1, '0);
    wr_en = 1'b0; go = 1'b0;
    step(); chk_o("t5 idle a", 0, 0, 0, '0);
    step(); chk_o("t5 idle b", 0, 0, 0, '0);
    launch(5'd1);
    chk_o("t5 rerun start", 1, 1, 0, '0);
    step(); chk_o("t5 rerun slot0", 1, 0, 0, big[0]);
    step(); chk_o("t5 rerun done", 1, 0, 1, '0);
    step(); chk_o("t5 rerun idle", 0, 0, 0, '0);

    // Reset mid-stream aborts; replay starts from slot0.
    launch(5'd4);
    chk_o("t6 start", 1, 1, 0, '0);
    step(); chk_o("t6 slot0", 1, 0, 0, big[0]);
    step(); chk_o("t6 slot1", 1, 0, 0, big[1]);
    #2 rst = 1'b1;
    #1 chk_o("t6 async reset", 0, 0, 0, '0);
    #1 rst = 1'b0;
    step(); chk_o("t6 post reset a", 0, 0, 0, '0);
    step(); chk_o("t6 post reset b", 0, 0, 0, '0);
    // Same-cycle write and go: stream sees the new slot0.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = s_new;
    launch(5'd4);
    wr_en = 1'b0;
    chk_o("t6 replay start", 1, 1, 0, '0);
    step(); chk_o("t6 replay slot0", 1, 0, 0, s_new);
    for (int i = 1; i < 4; i++) begin
      step(); chk_o($sformatf("t6 replay slot%0d", i), 1, 0, 0, big[i]);
    end
    step(); chk_o("t6 replay done", 1, 0, 1, '0);
    step(); chk_o("t6 replay idle", 0, 0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gust_schedule_feeder.md
# gust_schedule_feeder

Upstream stage of the GUST SpMV core (`main`). It holds one edge-colored schedule of per-lane slots (matrix value, vector value, column/psum index, signal bit) in a local buffer. On command it issues the one-cycle `start` pulse, then streams the slots to `main`'s `val`/`vec_val`/`ind`/`signals` inputs, one slot per cycle. A `hold` input inserts bubbles, and a `done` pulse marks the end of the stream.

## Interface
- `N`, 2, lane count; must match `main`.
- `value_size`, 32, IEEE-754 single word width.
- `index_size`, 3, per-lane index width.
- `DEPTH`, 16, schedule slots held; power of two.
- `AW`, $clog2(DEPTH), slot address width.
- Derived `W = N*(2*value_size+index_size+1)`, slot width. Packing, LSB first: val, vec_val, ind, signals, each N-lane packed with lane 0 in the LSBs.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write one slot into the buffer.
- `wr_addr`  in  AW  slot address.
- `wr_data`  in  W  packed slot.
- `len`  in  AW+1  number of slots to stream; sampled on `go`.
- `go`  in  1  start a stream; single-cycle request.
- `hold`  in  1  stall: insert a bubble this cycle.
- `busy`  out  1  high from the `go` acceptance through the `done` cycle.
- `done`  out  1  one-cycle pulse after the final slot.
- `start`  out  1  to `main.start`.
- `val`  out  N*value_size  to `main.val`.
- `vec_val`  out  N*value_size  to `main.vec_val`.
- `ind`  out  N*index_size  to `main.ind`.
- `signals`  out  N  to `main.signals`.

## Operation
- FSM states: IDLE, START, STREAM, DONE.
- IDLE:
  - `go` with `len`≠0 → START. The feeder latches `len`, clamped to DEPTH, and clears the slot pointer.
  - `go` with `len`=0 → DONE, with no `start` issued.
- START: for one cycle, `start`=1 and all data outputs are 0. Then → STREAM.
- STREAM:
  - Each cycle with `hold`=0, the slot at the pointer is registered onto the outputs and the pointer increments.
  - With `hold`=1, the outputs are a bubble (all-zero `val`/`vec_val`/`ind`/`signals`) and the pointer does not move.
  - After the slot at `len-1` is issued → DONE.
- DONE: for one cycle, `done`=1 and the outputs are a bubble. Then → IDLE.
- `go` outside IDLE is ignored.
- `wr_en` while `busy`=1 is ignored; the schedule is frozen during a stream. `wr_en` in IDLE writes on that edge. A same-cycle `wr_en` + `go` writes first, so the stream sees the new data.
- The pointer never wraps. `len`>DEPTH is clamped to DEPTH.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

## Timing
- Reset, asynchronous: state goes to IDLE; `start`, `done`, `busy`, `val`, `vec_val`, `ind`, `signals` all go to 0; the pointer is cleared. Buffer contents are not reset.
- Reset asserted mid-stream aborts immediately. No `done` is produced, and the next `go` after release is accepted normally.
- `go` sampled at edge t:
  - `busy`=1 and `start`=1 during cycle t+1.
  - Slot k is on the outputs during cycle t+2+k+h, where h = hold cycles seen so far.
  - `done`=1 during cycle t+2+len+H, where H = total hold cycles.
  - `busy` falls one cycle after `done`.
- `hold` is sampled at the edge that would load the next slot. `hold` in START or DONE has no effect.
- Throughput is one slot per cycle. Back-to-back streams are separated by at least one IDLE cycle.

## Structure
- Shared package `gust_pkg`:
  - state enum (IDLE/START/STREAM/DONE);
  - `W` slot-width function;
  - lane field offset functions shared with `main` and the benches.
- Sub-module `gust_schedule_ram`: a DEPTH×W register array with synchronous write and combinational read, and no reset. The FSM, pointer and output registers stay in the top module.

## Test plan
- Load 2 slots: slot0 = lanes (3F8CCCCD, 40066666) for both val and vec_val, ind = (1, 2), signals = 0; slot1 = zeros, ind = (2, 1), signals = 11b. `go` with `len`=2 → `start` in cycle t+1, slot0 in t+2, slot1 in t+3, `done` in t+4. Lane values must exactly match what was loaded.
- Same schedule with `hold`=1 for one cycle in the middle → one all-zero bubble between slot0 and slot1, and `done` delayed by 1.
- `go` with `len`=0 → `done` in t+1, `start` never asserted, `busy` high for exactly 1 cycle.
- `len`=20 with DEPTH=16 → exactly 16 slots issued in order 0..15, then `done`.
- `wr_en` to slot0 during a stream and `go` during a stream → both ignored; a rerun shows the original slot0 and exactly one `done`.
- `rst` pulsed in the middle of a 4-slot stream → all outputs 0 asynchronously, no `done`. A subsequent `go` replays from slot0.
